// File: rtl/decode_regfile_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_regfile_stage
// Purpose  : RV instruction-decode stage with an integrated register file.
//            Reads operands (with same-cycle write-back bypass), builds the
//            sign-extended immediate and control bits, and registers them in
//            a single ID/EX slot behind a valid/ready handshake. Detects
//            load-use hazards against the slot and inserts a bubble.
// Ports    : clk, reset                 clock, synchronous active-high reset
//            in_valid/in_ready, instr, pc   fetch side
//            flush                      kill slot and this cycle's input
//            wb_en, wb_rd, wb_data      register-file write port
//            out_valid/out_ready        EX side handshake
//            out_ctrl                   {alu_src,mem_to_reg,reg_write,
//                                        mem_read,mem_write,branch_en}
//            out_val_a/_b, out_store, out_imm, out_rd/rs1/rs2,
//            out_funct3/funct7/opcode, out_pc, illegal   slot contents
// Revision : 1.0 - initial release
// ============================================================================
module decode_regfile_stage #(
  parameter int XLEN       = 64,
  parameter int NUM_REGS   = 32,
  parameter int INIT_INDEX = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_ctrl,
  output logic [XLEN-1:0] out_val_a,
  output logic [XLEN-1:0] out_val_b,
  output logic [XLEN-1:0] out_store,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [6:0]      out_opcode,
  output logic [XLEN-1:0] out_pc,
  output logic            illegal
);

  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i      = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;

  // Bit position of mem_read inside the ctrl vector.
  localparam int c_ctrl_mem_read = 2;

  typedef struct packed {
    logic            valid;
    logic            illegal;
    logic [5:0]      ctrl;
    logic [XLEN-1:0] val_a;
    logic [XLEN-1:0] val_b;
    logic [XLEN-1:0] store;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [6:0]      opcode;
    logic [XLEN-1:0] pc;
  } slot_t;

  slot_t           slot_q, slot_d;
  logic [XLEN-1:0] regs_q [NUM_REGS];

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic            w_rs1_ok, w_rs2_ok, w_wb_ok;
  logic            w_wb_we;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;
  logic [5:0]      w_ctrl;
  logic [XLEN-1:0] w_imm;
  logic            w_known, w_use_rs2;
  logic            w_stall, w_load;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b;

  assign w_opcode = instr[6:0];
  assign w_rd     = instr[11:7];
  assign w_rs1    = instr[19:15];
  assign w_rs2    = instr[24:20];

  // An index is usable only if its bits above the register-file index width
  // are zero; out-of-range reads give 0 and out-of-range writes are ignored.
  generate
    if (RW >= 5) begin : g_full_idx
      assign w_rs1_ok = 1'b1;
      assign w_rs2_ok = 1'b1;
      assign w_wb_ok  = 1'b1;
    end else begin : g_part_idx
      assign w_rs1_ok = ~|w_rs1[4:RW];
      assign w_rs2_ok = ~|w_rs2[4:RW];
      assign w_wb_ok  = ~|wb_rd[4:RW];
    end
  endgenerate

  assign w_wb_we = wb_en && w_wb_ok && (wb_rd != 5'd0);

  // Register file: reset reinitialises contents and drops any concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (INIT_INDEX != 0) ? XLEN'(i) : '0;
      end
    end else if (w_wb_we) begin
      regs_q[wb_rd[RW-1:0]] <= wb_data;
    end
  end

  // Operand read with bypass of the write-back happening this cycle.
  always_comb begin
    w_rs1_val = '0;
    if (w_rs1_ok && (w_rs1 != 5'd0)) begin
      if (w_wb_we && (wb_rd == w_rs1)) w_rs1_val = wb_data;
      else                              w_rs1_val = regs_q[w_rs1[RW-1:0]];
    end
  end

  always_comb begin
    w_rs2_val = '0;
    if (w_rs2_ok && (w_rs2 != 5'd0)) begin
      if (w_wb_we && (wb_rd == w_rs2)) w_rs2_val = wb_data;
      else                              w_rs2_val = regs_q[w_rs2[RW-1:0]];
    end
  end

  assign w_imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign w_imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    w_ctrl    = 6'b000000;
    w_imm     = '0;
    w_known   = 1'b1;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      c_op_r:      begin w_ctrl = 6'b001000; w_use_rs2 = 1'b1; end
      c_op_i:      begin w_ctrl = 6'b101000; w_imm = w_imm_i; end
      c_op_load:   begin w_ctrl = 6'b111100; w_imm = w_imm_i; end
      c_op_store:  begin w_ctrl = 6'b100010; w_imm = w_imm_s; w_use_rs2 = 1'b1; end
      c_op_branch: begin w_ctrl = 6'b000001; w_imm = w_imm_b; w_use_rs2 = 1'b1; end
      default:     w_known = 1'b0;
    endcase
  end

  // Load-use hazard: the slot holds a load whose destination this instruction
  // reads. Every supported opcode reads rs1.
  assign w_stall = slot_q.valid && slot_q.ctrl[c_ctrl_mem_read] &&
                   (slot_q.rd != 5'd0) &&
                   ((w_known   && (w_rs1 == slot_q.rd)) ||
                    (w_use_rs2 && (w_rs2 == slot_q.rd)));

  assign in_ready = !w_stall && (!slot_q.valid || out_ready);
  assign w_load   = in_valid && in_ready;

  always_comb begin
    slot_d = slot_q;
    if (flush) begin
      slot_d.valid   = 1'b0;
      slot_d.illegal = 1'b0;
    end else if (w_load) begin
      slot_d.valid   = 1'b1;
      slot_d.illegal = !w_known;
      slot_d.ctrl    = w_ctrl;
      slot_d.val_a   = w_rs1_val;
      slot_d.val_b   = w_ctrl[5] ? w_imm : w_rs2_val;
      slot_d.store   = w_rs2_val;
      slot_d.imm     = w_imm;
      slot_d.rd      = w_rd;
      slot_d.rs1     = w_rs1;
      slot_d.rs2     = w_rs2;
      slot_d.funct3  = instr[14:12];
      slot_d.funct7  = instr[31:25];
      slot_d.opcode  = w_opcode;
      slot_d.pc      = pc;
    end else if (out_ready) begin
      // Consumed, or bubbled by a stall; data fields are left as they were.
      slot_d.valid   = 1'b0;
      slot_d.illegal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign out_valid  = slot_q.valid;
  assign illegal    = slot_q.illegal;
  assign out_ctrl   = slot_q.ctrl;
  assign out_val_a  = slot_q.val_a;
  assign out_val_b  = slot_q.val_b;
  assign out_store  = slot_q.store;
  assign out_imm    = slot_q.imm;
  assign out_rd     = slot_q.rd;
  assign out_rs1    = slot_q.rs1;
  assign out_rs2    = slot_q.rs2;
  assign out_funct3 = slot_q.funct3;
  assign out_funct7 = slot_q.funct7;
  assign out_opcode = slot_q.opcode;
  assign out_pc     = slot_q.pc;

endmodule
`default_nettype wire

// File: tb/tb_decode_regfile_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_regfile_stage
// Purpose  : Directed, table-driven bench for decode_regfile_stage with
//            hand-written sequences for stall, backpressure, flush and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_regfile_stage;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, wb_en, out_ready;
  logic        in_ready, out_valid, illegal;
  logic [31:0] instr;
  logic [63:0] pc, wb_data;
  logic [4:0]  wb_rd;
  logic [5:0]  out_ctrl;
  logic [63:0] out_val_a, out_val_b, out_store, out_imm, out_pc;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7, out_opcode;

  int tests = 0;
  int fails = 0;

  decode_regfile_stage #(.XLEN(64), .NUM_REGS(32), .INIT_INDEX(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_val_a(out_val_a), .out_val_b(out_val_b),
    .out_store(out_store), .out_imm(out_imm), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_opcode(out_opcode), .out_pc(out_pc),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [5:0]  ctrl;
    logic [63:0] a, b, st, imm;
    logic        ill;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] i, input logic [63:0] p, input logic we,
      input logic [4:0] wr, input logic [63:0] wd, input logic [5:0] c, input logic [63:0] a,
      input logic [63:0] b, input logic [63:0] st, input logic [63:0] imm, input logic ill,
      input logic [4:0] rd);
    vec_t v;
    v.instr = i; v.pc = p; v.wb_en = we; v.wb_rd = wr; v.wb_data = wd;
    v.ctrl = c; v.a = a; v.b = b; v.st = st; v.imm = imm; v.ill = ill; v.rd = rd;
    vecs.push_back(v);
  endtask

  // Issue one instruction with EX always ready and check the slot one cycle later.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    in_valid = 1'b1; instr = v.instr; pc = v.pc;
    wb_en = v.wb_en; wb_rd = v.wb_rd; wb_data = v.wb_data;
    out_ready = 1'b1; flush = 1'b0;
    #1 chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; wb_en = 1'b0;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_ctrl"},  64'(out_ctrl),  64'(v.ctrl));
    chk({tag, "_val_a"}, out_val_a, v.a);
    chk({tag, "_val_b"}, out_val_b, v.b);
    chk({tag, "_store"}, out_store, v.st);
    chk({tag, "_imm"},   out_imm,   v.imm);
    chk({tag, "_illegal"}, 64'(illegal), 64'(v.ill));
    chk({tag, "_rd"},    64'(out_rd),  64'(v.rd));
    chk({tag, "_pc"},    out_pc,    v.pc);
  endtask

  initial begin
    vec_t tmp;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    instr = 32'h0; pc = 64'h0; wb_rd = 5'd0; wb_data = 64'h0;

    // instr, pc, wb_en, wb_rd, wb_data, ctrl, a, b, store, imm, illegal, rd
    add_vec(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP_R), 64'h1000, 1'b0, 5'd0, 64'h0,
            6'b001000, 64'd1, 64'd2, 64'd2, 64'd0, 1'b0, 5'd3);
    add_vec(enc_i(12'hFFC, 5'd5, 3'd0, 5'd6, OP_I), 64'h1004, 1'b1, 5'd5, 64'hDEAD,
            6'b101000, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFC, 64'd28, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 5'd6);
    add_vec(enc_r(7'h00, 5'd5, 5'd0, 3'd0, 5'd9, OP_R), 64'h1008, 1'b1, 5'd0, 64'h55,
            6'b001000, 64'd0, 64'hDEAD, 64'hDEAD, 64'd0, 1'b0, 5'd9);
    add_vec(enc_s(12'd8, 5'd2, 5'd1, 3'd2, OP_S), 64'h100C, 1'b0, 5'd0, 64'h0,
            6'b100010, 64'd1, 64'd8, 64'd2, 64'd8, 1'b0, 5'd8);
    add_vec(enc_r(7'h00, 5'd4, 5'd3, 3'd0, 5'd1, 7'h7F), 64'h1010, 1'b0, 5'd0, 64'h0,
            6'b000000, 64'd3, 64'd4, 64'd4, 64'd0, 1'b1, 5'd1);
    add_vec(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0, OP_B), 64'h1014, 1'b0, 5'd0, 64'h0,
            6'b000001, 64'd1, 64'd2, 64'd2, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 5'd25);
    add_vec(enc_i(12'd16, 5'd5, 3'd3, 5'd11, OP_L), 64'h1018, 1'b0, 5'd0, 64'h0,
            6'b111100, 64'hDEAD, 64'd16, 64'd16, 64'd16, 1'b0, 5'd11);
    add_vec(enc_s(12'hFF4, 5'd31, 5'd9, 3'd2, OP_S), 64'h101C, 1'b1, 5'd31, 64'h1234_5678_9ABC_DEF0,
            6'b100010, 64'd9, 64'hFFFF_FFFF_FFFF_FFF4, 64'h1234_5678_9ABC_DEF0,
            64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 5'd20);
    add_vec(enc_b(13'd16, 5'd3, 5'd31, 3'd1, OP_B), 64'h1020, 1'b0, 5'd0, 64'h0,
            6'b000001, 64'h1234_5678_9ABC_DEF0, 64'd3, 64'd3, 64'd16, 1'b0, 5'd16);
    add_vec(enc_r(7'h20, 5'd1, 5'd1, 3'd0, 5'd12, OP_R), 64'h1024, 1'b1, 5'd1, 64'hCAFE,
            6'b001000, 64'hCAFE, 64'hCAFE, 64'hCAFE, 64'd0, 1'b0, 5'd12);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_valid",   64'(out_valid), 64'd0);
    chk("rst_illegal", 64'(illegal),   64'd0);
    chk("rst_ctrl",    64'(out_ctrl),  64'd0);
    chk("rst_val_a",   out_val_a,      64'd0);
    chk("rst_imm",     out_imm,        64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[k]) run_vec(vecs[k], $sformatf("v%0d", k));

    // Reset mid-operation: slot cleared, regfile reinitialised, concurrent wb dropped
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP_R);
    wb_en = 1'b1; wb_rd = 5'd4; wb_data = 64'h99;
    @(posedge clk); #1;
    chk("rmid_valid", 64'(out_valid), 64'd0);
    chk("rmid_ctrl",  64'(out_ctrl),  64'd0);
    chk("rmid_val_a", out_val_a,      64'd0);
    @(negedge clk); reset = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    tmp.instr = enc_r(7'h00, 5'd5, 5'd4, 3'd0, 5'd14, OP_R); tmp.pc = 64'h2000;
    tmp.wb_en = 1'b0; tmp.wb_rd = 5'd0; tmp.wb_data = 64'h0; tmp.ctrl = 6'b001000;
    tmp.a = 64'd4; tmp.b = 64'd5; tmp.st = 64'd5; tmp.imm = 64'd0; tmp.ill = 1'b0; tmp.rd = 5'd14;
    run_vec(tmp, "rmid_add");

    // Load-use: ld x7,0(x1) then add x8,x7,x2
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; instr = enc_i(12'd0, 5'd1, 3'd3, 5'd7, OP_L);
    @(posedge clk); #1;
    chk("lu_ld_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    instr = enc_r(7'h00, 5'd2, 5'd7, 3'd0, 5'd8, OP_R);
    #1 chk("lu_stall_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("lu_bubble_valid", 64'(out_valid), 64'd0);
    @(negedge clk); #1;
    chk("lu_resume_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lu_add_valid", 64'(out_valid), 64'd1);
    chk("lu_add_rd",    64'(out_rd),    64'd8);
    chk("lu_add_val_a", out_val_a,      64'd7);
    chk("lu_add_val_b", out_val_b,      64'd2);

    // Backpressure then flush (with a concurrent write-back)
    @(negedge clk);                      // let the slot drain
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP_R);
    @(posedge clk); #1;
    instr = enc_i(12'd5, 5'd1, 3'd0, 5'd13, OP_I);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", c),    64'(out_valid), 64'd1);
      chk($sformatf("bp%0d_rd", c),       64'(out_rd),    64'd3);
      chk($sformatf("bp%0d_val_a", c),    out_val_a,      64'd1);
      chk($sformatf("bp%0d_val_b", c),    out_val_b,      64'd2);
      chk($sformatf("bp%0d_in_ready", c), 64'(in_ready),  64'd0);
    end
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1; wb_en = 1'b1; wb_rd = 5'd20; wb_data = 64'h77;
    @(posedge clk); #1;
    chk("flush_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    #1 chk("flush_after_valid", 64'(out_valid), 64'd0);
    tmp.instr = enc_r(7'h00, 5'd0, 5'd20, 3'd0, 5'd21, OP_R); tmp.pc = 64'h3000;
    tmp.wb_en = 1'b0; tmp.wb_rd = 5'd0; tmp.wb_data = 64'h0; tmp.ctrl = 6'b001000;
    tmp.a = 64'h77; tmp.b = 64'd0; tmp.st = 64'd0; tmp.imm = 64'd0; tmp.ill = 1'b0; tmp.rd = 5'd21;
    run_vec(tmp, "flush_wb");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
